// File: rtl/lut_z_reader.sv
// Sequential reader for the Z-constant ROM: sweeps entries 0..ITER, one word at a time,
// presenting each captured word on a valid/ready output until the consumer accepts it.
module lut_z_reader #(
    parameter int P = 32,
    parameter int D = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [D-1:0] ITER,
    input  logic         ABORT,
    output logic         EN_ROM1,
    output logic [D-1:0] ADRS,
    input  logic [P-1:0] ROM_D,
    output logic [P-1:0] OUT_D,
    output logic [D-1:0] OUT_IDX,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic         OUT_LAST,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPT    = 3'd2,
        PRESENT = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam logic [D-1:0] IDX_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [D-1:0] idx, idx_nxt;
    logic [D-1:0] iter_q, iter_nxt;
    logic         capture;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        iter_nxt  = iter_q;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    iter_nxt  = ITER;
                    idx_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = CAPT;
            CAPT: begin
                capture   = 1'b1;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (OUT_READY) begin
                    if (OUT_LAST) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx + IDX_ONE;
                        state_nxt = FETCH;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over acceptance and suppresses any capture in flight.
        if (ABORT && (state != IDLE)) begin
            state_nxt = IDLE;
            idx_nxt   = idx;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            iter_q   <= '0;
            OUT_D    <= '0;
            OUT_IDX  <= '0;
            OUT_LAST <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            iter_q <= iter_nxt;
            if (capture) begin
                OUT_D    <= ROM_D;
                OUT_IDX  <= idx;
                OUT_LAST <= (idx == iter_q);
            end
        end
    end

    assign EN_ROM1   = (state == FETCH);
    assign ADRS      = idx;
    assign OUT_VALID = (state == PRESENT);
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FIN);

endmodule

// File: tb/tb_lut_z_reader.sv
// Bench for lut_z_reader: a registered ROM model feeds the DUT; each sweep is checked
// against the expected word list derived from the ROM contents and the requested range.
module tb_lut_z_reader;

    localparam int P = 32;
    localparam int D = 5;
    localparam int N = 32;
    localparam int BUDGET = 2000;

    logic         clk = 1'b0;
    logic         rst, start, abort, out_ready;
    logic [D-1:0] iter;
    logic         en_rom1, out_valid, out_last, busy, done;
    logic [D-1:0] adrs, out_idx;
    logic [P-1:0] rom_q, out_d;
    logic [P-1:0] rom [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Registered ROM: data for the enabled address appears the cycle after, zero otherwise.
    always_ff @(posedge clk) rom_q <= en_rom1 ? rom[adrs] : '0;

    lut_z_reader #(.P(P), .D(D)) dut (
        .CLK(clk), .RST(rst), .START(start), .ITER(iter), .ABORT(abort),
        .EN_ROM1(en_rom1), .ADRS(adrs), .ROM_D(rom_q), .OUT_D(out_d),
        .OUT_IDX(out_idx), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_LAST(out_last), .BUSY(busy), .DONE(done)
    );

    // Runs one sweep of entries 0..it; expected word k is {rom[k], k, k==it}.
    task automatic do_sweep(input string nm, input int it, input int stall_at, input int stall_len,
                            input int restart_at, input int abort_at, input bit rnd_ready,
                            output int n_words, output int n_done, output int n_en);
        int exp_i, c, stalled, first_valid, post;
        bit aborted, finished, abort_chk;
        logic [D-1:0] it_v;
        n_words = 0; n_done = 0; n_en = 0;
        exp_i = 0; stalled = 0; first_valid = -1; post = 0;
        aborted = 0; finished = 0; abort_chk = 0;
        it_v = it[D-1:0];
        @(negedge clk);
        start = 1'b1; iter = it_v; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; iter = D'($urandom);
        c = 1;
        while (c < BUDGET) begin
            if (en_rom1) begin
                n_en++;
                total++;
                if (adrs !== exp_i[D-1:0]) begin
                    bad++; $display("FAIL %s adrs: got %0d want %0d", nm, adrs, exp_i);
                end
            end
            if (done) n_done++;
            if (abort_chk) begin
                abort_chk = 0;
                total++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL %s abort: valid=%b busy=%b want 0 0", nm, out_valid, busy);
                end
            end
            if (finished && post == 0) begin
                total++;
                if (done !== 1'b1) begin
                    bad++; $display("FAIL %s done_timing: done=%b want 1", nm, done);
                end
            end
            if (out_valid) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    total++;
                    if (c != 3) begin
                        bad++; $display("FAIL %s latency: got %0d want 3", nm, c);
                    end
                end
                total++;
                if (out_d !== rom[exp_i] || out_idx !== exp_i[D-1:0] || out_last !== (exp_i == it)) begin
                    bad++;
                    $display("FAIL %s word: got d=%h idx=%0d last=%b want d=%h idx=%0d last=%b",
                             nm, out_d, out_idx, out_last, rom[exp_i], exp_i, (exp_i == it));
                end
            end
            if (finished || aborted) begin
                post++;
                if (post > 3) break;
            end
            abort = 1'b0; start = 1'b0;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && exp_i == stall_at && stalled < stall_len) begin
                out_ready = 1'b0; stalled++;
            end
            if (out_valid && exp_i == restart_at) begin
                start = 1'b1; iter = D'($urandom);
            end
            if (out_valid && exp_i == abort_at && !aborted) begin
                abort = 1'b1; out_ready = 1'b1; aborted = 1; abort_chk = 1;
            end else if (out_valid && out_ready) begin
                exp_i++; n_words++;
                if (exp_i > it) finished = 1;
            end
            @(negedge clk);
            c++;
        end
        abort = 1'b0; start = 1'b0; out_ready = 1'b1;
        if (c >= BUDGET) begin
            total++; bad++;
            $display("FAIL %s timeout: words=%0d want %0d", nm, n_words, it + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; iter = D'($urandom); out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({en_rom1, adrs, out_d, out_idx, out_valid, out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: en=%b adrs=%0d d=%h idx=%0d v=%b l=%b b=%b dn=%b want all 0",
                     en_rom1, adrs, out_d, out_idx, out_valid, out_last, busy, done);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        int w, d, e;
        do_sweep("single", 0, -1, 0, -1, -1, 0, w, d, e);
        total++;
        if (w != 1 || d != 1 || e != 1) begin
            bad++; $display("FAIL single_counts: words=%0d done=%0d en=%0d want 1 1 1", w, d, e);
        end
    endtask

    task automatic test_iter5();
        int w, d, e;
        do_sweep("iter5", 5, -1, 0, -1, -1, 0, w, d, e);
        total++;
        if (w != 6 || d != 1 || e != 6) begin
            bad++; $display("FAIL iter5_counts: words=%0d done=%0d en=%0d want 6 1 6", w, d, e);
        end
    endtask

    task automatic test_full_stall();
        int w, d, e;
        do_sweep("full_stall", 31, 2, 10, -1, -1, 0, w, d, e);
        total++;
        if (w != 32 || d != 1 || e != 32) begin
            bad++; $display("FAIL full_stall_counts: words=%0d done=%0d en=%0d want 32 1 32", w, d, e);
        end
    endtask

    task automatic test_back_to_back();
        int w, d, e;
        do_sweep("restart", 3, -1, 0, 1, -1, 0, w, d, e);
        total++;
        if (w != 4 || d != 1 || e != 4) begin
            bad++; $display("FAIL restart_counts: words=%0d done=%0d en=%0d want 4 1 4", w, d, e);
        end
    endtask

    task automatic test_abort();
        int w, d, e;
        do_sweep("abort", 5, -1, 0, -1, 2, 0, w, d, e);
        total++;
        if (w != 2 || d != 0 || e != 3) begin
            bad++; $display("FAIL abort_counts: words=%0d done=%0d en=%0d want 2 0 3", w, d, e);
        end
        do_sweep("after_abort", 2, -1, 0, -1, -1, 0, w, d, e);
        total++;
        if (w != 3 || d != 1 || e != 3) begin
            bad++; $display("FAIL after_abort_counts: words=%0d done=%0d en=%0d want 3 1 3", w, d, e);
        end
    endtask

    task automatic test_rst_capt();
        @(negedge clk);
        start = 1'b1; iter = 5'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({en_rom1, adrs, out_d, out_idx, out_valid, out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL rst_capt_outputs: en=%b adrs=%0d d=%h idx=%0d v=%b l=%b b=%b dn=%b want all 0",
                     en_rom1, adrs, out_d, out_idx, out_valid, out_last, busy, done);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_d !== '0) begin
                bad++;
                $display("FAIL rst_capt_resume: v=%b busy=%b d=%h want 0 0 0", out_valid, busy, out_d);
            end
        end
    endtask

    task automatic test_random();
        int w, d, e, it;
        for (int s = 0; s < 6; s++) begin
            it = int'($urandom_range(0, N - 1));
            do_sweep("random", it, -1, 0, -1, -1, 1, w, d, e);
            total++;
            if (w != it + 1 || d != 1 || e != it + 1) begin
                bad++;
                $display("FAIL random_counts: words=%0d done=%0d en=%0d want %0d 1 %0d", w, d, e, it + 1, it + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) rom[i] = $urandom;
        rom[0]  = 32'hBF8C9F54;
        rom[3]  = 32'hBE002AC4;
        rom[4]  = 32'hBE002AC4;
        rom[31] = 32'hB1000000;
        rst = 1'b1; start = 1'b0; abort = 1'b0; iter = '0; out_ready = 1'b1;
        test_reset();
        test_single();
        test_iter5();
        test_full_stall();
        test_back_to_back();
        test_abort();
        test_rst_capt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
